scan_rasterizer: RTL and testbench

- Sequential, parametrised rasteriser. Accepts one screen-space triangle per handshake and walks its clipped bounding box in raster order, one pixel per cycle.
- Evaluates edge functions incrementally and emits only covered pixels as fragments, with barycentric and depth-weighted barycentric values.
- Sits between triangle setup/transform and the fragment shader / framebuffer writer. Both sides use valid/ready.

---
 rtl/scan_rasterizer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_scan_rasterizer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_rasterizer.sv
// scan_rasterizer: accepts one screen-space triangle per valid/ready handshake,
// walks its screen-clipped bounding box in raster order (one pixel per cycle)
// using incrementally updated edge functions, and emits only covered pixels
// together with barycentric and depth-weighted barycentric values.
module scan_rasterizer #(
    parameter int XW     = 10,
    parameter int YW     = 10,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ZW     = 7,
    parameter int ZFRAC  = 7,
    localparam int EW    = XW + YW + 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tri_valid,
    output logic          tri_ready,
    input  logic [XW-1:0] ax,
    input  logic [XW-1:0] bx,
    input  logic [XW-1:0] cx,
    input  logic [YW-1:0] ay,
    input  logic [YW-1:0] by,
    input  logic [YW-1:0] cy,
    input  logic [ZW-1:0] az,
    input  logic [ZW-1:0] bz,
    input  logic [ZW-1:0] cz,
    output logic          frag_valid,
    input  logic          frag_ready,
    output logic [XW-1:0] frag_x,
    output logic [YW-1:0] frag_y,
    output logic [EW-2:0] frag_u,
    output logic [EW-2:0] frag_v,
    output logic [EW-2:0] frag_w,
    output logic [EW-2:0] frag_uz,
    output logic [EW-2:0] frag_vz,
    output logic [EW-2:0] frag_wz,
    output logic [EW:0]   frag_sz,
    output logic          tri_done
);

    localparam int FW = EW - 1;   // unsigned fragment value width
    localparam int SW = EW + 1;   // depth-sum width
    localparam int PW = EW + ZW;  // weighted product width before shift

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_SCAN  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic [1:0]           r_state;
    logic [XW-1:0]        r_ax, r_bx, r_cx;
    logic [YW-1:0]        r_ay, r_by, r_cy;
    logic [ZW-1:0]        r_az, r_bz, r_cz;
    logic [XW-1:0]        r_x, r_xmin, r_xmax;
    logic [YW-1:0]        r_y, r_ymax;
    logic signed [EW-1:0] r_area_abs, r_v, r_w, r_row_v, r_row_w;
    logic signed [EW-1:0] r_dvx, r_dwx, r_dvy, r_dwy;

    logic                 r_frag_valid;
    logic [XW-1:0]        r_frag_x;
    logic [YW-1:0]        r_frag_y;
    logic [FW-1:0]        r_frag_u, r_frag_v, r_frag_w;
    logic [FW-1:0]        r_frag_uz, r_frag_vz, r_frag_wz;
    logic [SW-1:0]        r_frag_sz;

    // Setup-cycle geometry, evaluated from the latched vertices.
    logic signed [EW-1:0] w_abx, w_aby, w_acx, w_acy, w_area;
    logic signed [EW-1:0] w_dx, w_dy, w_v_raw, w_w_raw;
    logic                 w_neg, w_empty;
    logic [XW-1:0]        w_xmin_ab, w_xmax_ab, w_xmax_raw, w_xmin, w_xmax;
    logic [YW-1:0]        w_ymin_ab, w_ymax_ab, w_ymax_raw, w_ymin, w_ymax;

    assign w_abx = $signed(EW'(r_bx)) - $signed(EW'(r_ax));
    assign w_aby = $signed(EW'(r_by)) - $signed(EW'(r_ay));
    assign w_acx = $signed(EW'(r_cx)) - $signed(EW'(r_ax));
    assign w_acy = $signed(EW'(r_cy)) - $signed(EW'(r_ay));
    assign w_area = w_abx * w_acy - w_aby * w_acx;
    // Negative area means clockwise winding; every edge term is flipped so
    // coverage tests stay "all non-negative" regardless of winding.
    assign w_neg = w_area[EW-1];

    assign w_xmin_ab  = (r_bx < r_ax) ? r_bx : r_ax;
    assign w_xmin     = (r_cx < w_xmin_ab) ? r_cx : w_xmin_ab;
    assign w_xmax_ab  = (r_bx > r_ax) ? r_bx : r_ax;
    assign w_xmax_raw = (r_cx > w_xmax_ab) ? r_cx : w_xmax_ab;
    assign w_xmax     = (w_xmax_raw > X_LAST) ? X_LAST : w_xmax_raw;
    assign w_ymin_ab  = (r_by < r_ay) ? r_by : r_ay;
    assign w_ymin     = (r_cy < w_ymin_ab) ? r_cy : w_ymin_ab;
    assign w_ymax_ab  = (r_by > r_ay) ? r_by : r_ay;
    assign w_ymax_raw = (r_cy > w_ymax_ab) ? r_cy : w_ymax_ab;
    assign w_ymax     = (w_ymax_raw > Y_LAST) ? Y_LAST : w_ymax_raw;

    assign w_dx    = $signed(EW'(w_xmin)) - $signed(EW'(r_ax));
    assign w_dy    = $signed(EW'(w_ymin)) - $signed(EW'(r_ay));
    assign w_v_raw = w_dx * w_acy - w_dy * w_acx;
    assign w_w_raw = w_abx * w_dy - w_aby * w_dx;

    // A lower minimum than maximum only fails when clipping pushed xmax/ymax
    // below a vertex that lies entirely off-screen.
    assign w_empty = (w_area == {EW{1'b0}}) || (w_xmin > w_xmax) || (w_ymin > w_ymax);

    // Scan-cycle evaluation of the current pixel.
    logic signed [EW-1:0] w_u;
    logic                 w_cov, w_slot_free, w_adv, w_row_end, w_last, w_load;
    logic [PW-1:0]        w_uz_full, w_vz_full, w_wz_full;
    logic [FW-1:0]        w_uz, w_vz, w_wz;
    logic [SW-1:0]        w_sz;

    assign w_u         = r_area_abs - r_v - r_w;
    assign w_cov       = !w_u[EW-1] && !r_v[EW-1] && !r_w[EW-1];
    assign w_slot_free = !r_frag_valid || frag_ready;
    assign w_adv       = (r_state == S_SCAN) && w_slot_free;
    assign w_row_end   = (r_x == r_xmax);
    assign w_last      = w_row_end && (r_y == r_ymax);
    assign w_load      = w_adv && w_cov;

    assign w_uz_full = PW'(w_u[EW-2:0]) * PW'(r_az);
    assign w_vz_full = PW'(r_v[EW-2:0]) * PW'(r_bz);
    assign w_wz_full = PW'(r_w[EW-2:0]) * PW'(r_cz);
    assign w_uz      = FW'(w_uz_full >> ZFRAC);
    assign w_vz      = FW'(w_vz_full >> ZFRAC);
    assign w_wz      = FW'(w_wz_full >> ZFRAC);
    assign w_sz      = SW'(w_uz) + SW'(w_vz) + SW'(w_wz);

    // Control FSM: latch triangle, set up edge functions, walk the bbox, retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ax       <= '0;
            r_bx       <= '0;
            r_cx       <= '0;
            r_ay       <= '0;
            r_by       <= '0;
            r_cy       <= '0;
            r_az       <= '0;
            r_bz       <= '0;
            r_cz       <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_xmin     <= '0;
            r_xmax     <= '0;
            r_ymax     <= '0;
            r_area_abs <= '0;
            r_v        <= '0;
            r_w        <= '0;
            r_row_v    <= '0;
            r_row_w    <= '0;
            r_dvx      <= '0;
            r_dwx      <= '0;
            r_dvy      <= '0;
            r_dwy      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (tri_valid) begin
                        r_ax    <= ax;
                        r_bx    <= bx;
                        r_cx    <= cx;
                        r_ay    <= ay;
                        r_by    <= by;
                        r_cy    <= cy;
                        r_az    <= az;
                        r_bz    <= bz;
                        r_cz    <= cz;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_x        <= w_xmin;
                    r_y        <= w_ymin;
                    r_xmin     <= w_xmin;
                    r_xmax     <= w_xmax;
                    r_ymax     <= w_ymax;
                    r_area_abs <= w_neg ? -w_area : w_area;
                    r_v        <= w_neg ? -w_v_raw : w_v_raw;
                    r_w        <= w_neg ? -w_w_raw : w_w_raw;
                    r_row_v    <= w_neg ? -w_v_raw : w_v_raw;
                    r_row_w    <= w_neg ? -w_w_raw : w_w_raw;
                    r_dvx      <= w_neg ? -w_acy : w_acy;
                    r_dwx      <= w_neg ? w_aby : -w_aby;
                    r_dvy      <= w_neg ? w_acx : -w_acx;
                    r_dwy      <= w_neg ? -w_abx : w_abx;
                    r_state    <= w_empty ? S_DONE : S_SCAN;
                end
                S_SCAN: begin
                    if (w_adv) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else if (w_row_end) begin
                            r_x     <= r_xmin;
                            r_y     <= r_y + YW'(1);
                            r_v     <= r_row_v + r_dvy;
                            r_w     <= r_row_w + r_dwy;
                            r_row_v <= r_row_v + r_dvy;
                            r_row_w <= r_row_w + r_dwy;
                        end else begin
                            r_x <= r_x + XW'(1);
                            r_v <= r_v + r_dvx;
                            r_w <= r_w + r_dwx;
                        end
                    end
                end
                S_DONE: begin
                    if (w_slot_free) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Fragment output register: load on a covered pixel, drain on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frag_valid <= 1'b0;
            r_frag_x     <= '0;
            r_frag_y     <= '0;
            r_frag_u     <= '0;
            r_frag_v     <= '0;
            r_frag_w     <= '0;
            r_frag_uz    <= '0;
            r_frag_vz    <= '0;
            r_frag_wz    <= '0;
            r_frag_sz    <= '0;
        end else if (w_load) begin
            r_frag_valid <= 1'b1;
            r_frag_x     <= r_x;
            r_frag_y     <= r_y;
            r_frag_u     <= w_u[EW-2:0];
            r_frag_v     <= r_v[EW-2:0];
            r_frag_w     <= r_w[EW-2:0];
            r_frag_uz    <= w_uz;
            r_frag_vz    <= w_vz;
            r_frag_wz    <= w_wz;
            r_frag_sz    <= w_sz;
        end else if (frag_ready) begin
            r_frag_valid <= 1'b0;
        end
    end

    assign tri_ready  = (r_state == S_IDLE);
    assign tri_done   = (r_state == S_DONE) && w_slot_free;
    assign frag_valid = r_frag_valid;
    assign frag_x     = r_frag_x;
    assign frag_y     = r_frag_y;
    assign frag_u     = r_frag_u;
    assign frag_v     = r_frag_v;
    assign frag_w     = r_frag_w;
    assign frag_uz    = r_frag_uz;
    assign frag_vz    = r_frag_vz;
    assign frag_wz    = r_frag_wz;
    assign frag_sz    = r_frag_sz;

endmodule

// File: tb/tb_scan_rasterizer.sv
// Directed self-checking bench for scan_rasterizer (depth weights widened to
// 8 bits so a weight of 128 represents 1.0 with 7 fraction bits).
module tb_scan_rasterizer;

    localparam int XW    = 10;
    localparam int YW    = 10;
    localparam int ZW    = 8;
    localparam int EW    = XW + YW + 3;
    localparam int SNAPW = 1 + XW + YW + 6 * (EW - 1) + EW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tri_valid = 1'b0;
    logic          tri_ready;
    logic [XW-1:0] ax = '0, bx = '0, cx = '0;
    logic [YW-1:0] ay = '0, by = '0, cy = '0;
    logic [ZW-1:0] az = '0, bz = '0, cz = '0;
    logic          frag_valid;
    logic          frag_ready = 1'b1;
    logic [XW-1:0] frag_x;
    logic [YW-1:0] frag_y;
    logic [EW-2:0] frag_u, frag_v, frag_w, frag_uz, frag_vz, frag_wz;
    logic [EW:0]   frag_sz;
    logic          tri_done;

    int n_checks = 0;
    int n_errors = 0;

    // Recorded by collect(): accepted fragments and per-cycle observations.
    int rx[64], ry[64], ru[64], rv[64], rw[64], ruz[64], rvz[64], rwz[64], rsz[64];
    int n_frags, done_cycle, done_count;
    bit hold_bad, timed_out, fv_seen;
    bit rdy_hist[256];

    scan_rasterizer #(.ZW(ZW)) dut (
        .clk(clk), .rst_n(rst_n), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .ax(ax), .bx(bx), .cx(cx), .ay(ay), .by(by), .cy(cy),
        .az(az), .bz(bz), .cz(cz),
        .frag_valid(frag_valid), .frag_ready(frag_ready),
        .frag_x(frag_x), .frag_y(frag_y),
        .frag_u(frag_u), .frag_v(frag_v), .frag_w(frag_w),
        .frag_uz(frag_uz), .frag_vz(frag_vz), .frag_wz(frag_wz),
        .frag_sz(frag_sz), .tri_done(tri_done)
    );

    always #5 clk = ~clk;

    // Offer one triangle; returns just after the handshake edge (cycle 0).
    task automatic send_tri(input int pax, input int pay, input int pbx, input int pby,
                            input int pcx, input int pcy, input int paz, input int pbz,
                            input int pcz);
        @(negedge clk);
        ax = XW'(pax); ay = YW'(pay);
        bx = XW'(pbx); by = YW'(pby);
        cx = XW'(pcx); cy = YW'(pcy);
        az = ZW'(paz); bz = ZW'(pbz); cz = ZW'(pcz);
        tri_valid = 1'b1;
        @(posedge clk);
        #1 tri_valid = 1'b0;
    endtask

    // Observe cycles 1..max after the handshake, optionally holding frag_ready
    // low for the first stall_n cycles in which a fragment is offered.
    task automatic collect(input int max_cycles, input int stall_n);
        int stall_left;
        bit snap_taken;
        logic [SNAPW-1:0] snap;
        n_frags = 0; done_cycle = -1; done_count = 0;
        hold_bad = 1'b0; timed_out = 1'b1; fv_seen = 1'b0;
        stall_left = stall_n; snap_taken = 1'b0; snap = '0;
        for (int k = 0; k < 256; k++) rdy_hist[k] = 1'b0;
        for (int k = 1; k <= max_cycles; k++) begin
            @(negedge clk);
            #1;
            if (k < 256) rdy_hist[k] = tri_ready;
            if (frag_valid) fv_seen = 1'b1;
            if (frag_valid && stall_left > 0) begin
                if (!snap_taken) begin
                    snap = {frag_valid, frag_x, frag_y, frag_u, frag_v, frag_w,
                            frag_uz, frag_vz, frag_wz, frag_sz};
                    snap_taken = 1'b1;
                end else if ({frag_valid, frag_x, frag_y, frag_u, frag_v, frag_w,
                              frag_uz, frag_vz, frag_wz, frag_sz} !== snap) begin
                    hold_bad = 1'b1;
                end
                frag_ready = 1'b0;
                stall_left--;
            end else begin
                frag_ready = 1'b1;
            end
            #1;
            if (frag_valid && frag_ready) begin
                if (n_frags < 64) begin
                    rx[n_frags] = int'(frag_x);   ry[n_frags] = int'(frag_y);
                    ru[n_frags] = int'(frag_u);   rv[n_frags] = int'(frag_v);
                    rw[n_frags] = int'(frag_w);   ruz[n_frags] = int'(frag_uz);
                    rvz[n_frags] = int'(frag_vz); rwz[n_frags] = int'(frag_wz);
                    rsz[n_frags] = int'(frag_sz);
                end
                n_frags++;
            end
            if (tri_done) begin
                done_count++;
                if (done_cycle < 0) done_cycle = k;
            end
            if (done_cycle > 0 && k >= done_cycle + 2) begin
                timed_out = 1'b0;
                break;
            end
        end
        frag_ready = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (tri_ready !== 1'b1 || frag_valid !== 1'b0 || tri_done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got ready=%b fvalid=%b done=%b expected 1 0 0",
                     tri_ready, frag_valid, tri_done);
        end
        n_checks++;
        if (frag_x !== '0 || frag_y !== '0 || frag_u !== '0 || frag_v !== '0 || frag_w !== '0 ||
            frag_uz !== '0 || frag_vz !== '0 || frag_wz !== '0 || frag_sz !== '0) begin
            n_errors++;
            $display("FAIL reset_data: got x=%0d y=%0d u=%0d sz=%0d expected all 0",
                     frag_x, frag_y, frag_u, frag_sz);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ccw();
        int idx, eu, ev, ew;
        send_tri(0, 0, 4, 0, 0, 4, 128, 128, 128);
        collect(200, 0);
        n_checks++;
        if (timed_out !== 1'b0) begin
            n_errors++; $display("FAIL ccw_timeout: got no tri_done expected tri_done");
        end
        n_checks++;
        if (n_frags != 15) begin
            n_errors++; $display("FAIL ccw_count: got %0d expected 15", n_frags);
        end
        n_checks++;
        if (done_cycle != 27 || done_count != 1) begin
            n_errors++;
            $display("FAIL ccw_done: got cycle=%0d pulses=%0d expected cycle=27 pulses=1",
                     done_cycle, done_count);
        end
        n_checks++;
        if (rx[0] != 0 || ry[0] != 0 || ru[0] != 16 || rv[0] != 0 || rw[0] != 0 ||
            ruz[0] != 16 || rsz[0] != 16) begin
            n_errors++;
            $display("FAIL ccw_first: got (%0d,%0d) u=%0d v=%0d w=%0d uz=%0d sz=%0d expected (0,0) 16 0 0 16 16",
                     rx[0], ry[0], ru[0], rv[0], rw[0], ruz[0], rsz[0]);
        end
        n_checks++;
        if (rx[10] != 1 || ry[10] != 2 || ru[10] != 4 || rv[10] != 4 || rw[10] != 8) begin
            n_errors++;
            $display("FAIL ccw_pix12: got (%0d,%0d) u=%0d v=%0d w=%0d expected (1,2) 4 4 8",
                     rx[10], ry[10], ru[10], rv[10], rw[10]);
        end
        idx = 0;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                if (x + y <= 4) begin
                    eu = 16 - 4 * x - 4 * y; ev = 4 * x; ew = 4 * y;
                    if (idx < n_frags && idx < 64) begin
                        n_checks++;
                        if (rx[idx] != x || ry[idx] != y || ru[idx] != eu || rv[idx] != ev ||
                            rw[idx] != ew || ruz[idx] != eu || rvz[idx] != ev ||
                            rwz[idx] != ew || rsz[idx] != 16) begin
                            n_errors++;
                            $display("FAIL ccw_frag%0d: got (%0d,%0d) u=%0d v=%0d w=%0d uz=%0d vz=%0d wz=%0d sz=%0d expected (%0d,%0d) %0d %0d %0d %0d %0d %0d 16",
                                     idx, rx[idx], ry[idx], ru[idx], rv[idx], rw[idx], ruz[idx],
                                     rvz[idx], rwz[idx], rsz[idx], x, y, eu, ev, ew, eu, ev, ew);
                        end
                    end
                    idx++;
                end
            end
        end
    endtask

    task automatic test_cw();
        int idx, eu, ev, ew, euz, evz, ewz;
        send_tri(0, 0, 0, 4, 4, 0, 128, 64, 192);
        collect(200, 0);
        n_checks++;
        if (n_frags != 15 || done_cycle != 27 || done_count != 1) begin
            n_errors++;
            $display("FAIL cw_count: got frags=%0d done=%0d pulses=%0d expected 15 27 1",
                     n_frags, done_cycle, done_count);
        end
        idx = 0;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                if (x + y <= 4) begin
                    eu = 16 - 4 * x - 4 * y; ev = 4 * y; ew = 4 * x;
                    euz = (eu * 128) >> 7; evz = (ev * 64) >> 7; ewz = (ew * 192) >> 7;
                    if (idx < n_frags && idx < 64) begin
                        n_checks++;
                        if (rx[idx] != x || ry[idx] != y || ru[idx] != eu || rv[idx] != ev ||
                            rw[idx] != ew || ruz[idx] != euz || rvz[idx] != evz ||
                            rwz[idx] != ewz || rsz[idx] != euz + evz + ewz) begin
                            n_errors++;
                            $display("FAIL cw_frag%0d: got (%0d,%0d) u=%0d v=%0d w=%0d uz=%0d vz=%0d wz=%0d sz=%0d expected (%0d,%0d) %0d %0d %0d %0d %0d %0d %0d",
                                     idx, rx[idx], ry[idx], ru[idx], rv[idx], rw[idx], ruz[idx],
                                     rvz[idx], rwz[idx], rsz[idx], x, y, eu, ev, ew, euz, evz,
                                     ewz, euz + evz + ewz);
                        end
                    end
                    idx++;
                end
            end
        end
    endtask

    task automatic test_degenerate();
        send_tri(1, 1, 3, 3, 5, 5, 128, 128, 128);
        collect(20, 0);
        n_checks++;
        if (fv_seen !== 1'b0 || n_frags != 0) begin
            n_errors++;
            $display("FAIL degen_frags: got fvalid_seen=%b frags=%0d expected 0 0", fv_seen, n_frags);
        end
        n_checks++;
        if (done_cycle != 2 || done_count != 1) begin
            n_errors++;
            $display("FAIL degen_done: got cycle=%0d pulses=%0d expected 2 1", done_cycle, done_count);
        end
        n_checks++;
        if (rdy_hist[2] !== 1'b0 || rdy_hist[3] !== 1'b1) begin
            n_errors++;
            $display("FAIL degen_ready: got c2=%b c3=%b expected 0 1", rdy_hist[2], rdy_hist[3]);
        end
    endtask

    task automatic test_backpressure();
        int idx;
        send_tri(0, 0, 4, 0, 0, 4, 128, 128, 128);
        collect(300, 10);
        n_checks++;
        if (hold_bad !== 1'b0) begin
            n_errors++; $display("FAIL bp_hold: got outputs changed during stall expected stable");
        end
        n_checks++;
        if (n_frags != 15 || done_cycle != 37 || done_count != 1) begin
            n_errors++;
            $display("FAIL bp_count: got frags=%0d done=%0d pulses=%0d expected 15 37 1",
                     n_frags, done_cycle, done_count);
        end
        idx = 0;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                if (x + y <= 4) begin
                    if (idx < n_frags && idx < 64) begin
                        n_checks++;
                        if (rx[idx] != x || ry[idx] != y || ru[idx] != 16 - 4 * x - 4 * y) begin
                            n_errors++;
                            $display("FAIL bp_frag%0d: got (%0d,%0d) u=%0d expected (%0d,%0d) u=%0d",
                                     idx, rx[idx], ry[idx], ru[idx], x, y, 16 - 4 * x - 4 * y);
                        end
                    end
                    idx++;
                end
            end
        end
    endtask

    task automatic test_clip();
        int max_x;
        send_tri(636, 0, 700, 0, 636, 8, 128, 128, 128);
        collect(300, 0);
        max_x = 0;
        for (int i = 0; i < n_frags && i < 64; i++) begin
            if (rx[i] > max_x) max_x = rx[i];
        end
        n_checks++;
        if (max_x > 639) begin
            n_errors++; $display("FAIL clip_maxx: got %0d expected <= 639", max_x);
        end
        n_checks++;
        if (n_frags != 33 || done_cycle != 38 || done_count != 1) begin
            n_errors++;
            $display("FAIL clip_count: got frags=%0d done=%0d pulses=%0d expected 33 38 1",
                     n_frags, done_cycle, done_count);
        end
        n_checks++;
        if (rx[0] != 636 || ry[0] != 0 || ru[0] != 512 || rx[32] != 636 || ry[32] != 8 ||
            ru[32] != 0 || rw[32] != 512) begin
            n_errors++;
            $display("FAIL clip_ends: got (%0d,%0d) u=%0d / (%0d,%0d) u=%0d w=%0d expected (636,0) 512 / (636,8) 0 512",
                     rx[0], ry[0], ru[0], rx[32], ry[32], ru[32], rw[32]);
        end
    endtask

    task automatic test_reset_mid_scan();
        bit saw;
        send_tri(0, 0, 4, 0, 0, 4, 128, 128, 128);
        for (int k = 0; k < 6; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (frag_valid !== 1'b0 || tri_ready !== 1'b1 || tri_done !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid: got fvalid=%b ready=%b done=%b expected 0 1 0",
                     frag_valid, tri_ready, tri_done);
        end
        saw = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (frag_valid || tri_done) saw = 1'b1;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (frag_valid || tri_done || !tri_ready) saw = 1'b1;
        end
        n_checks++;
        if (saw !== 1'b0) begin
            n_errors++; $display("FAIL rst_quiet: got activity after reset expected none");
        end
        send_tri(0, 0, 4, 0, 0, 4, 128, 128, 128);
        collect(200, 0);
        n_checks++;
        if (n_frags != 15 || done_cycle != 27 || done_count != 1) begin
            n_errors++;
            $display("FAIL rst_retry: got frags=%0d done=%0d pulses=%0d expected 15 27 1",
                     n_frags, done_cycle, done_count);
        end
        n_checks++;
        if (rx[14] != 0 || ry[14] != 4 || ru[14] != 0 || rw[14] != 16) begin
            n_errors++;
            $display("FAIL rst_last: got (%0d,%0d) u=%0d w=%0d expected (0,4) 0 16",
                     rx[14], ry[14], ru[14], rw[14]);
        end
    endtask

    initial begin
        test_reset();
        test_ccw();
        test_cw();
        test_degenerate();
        test_backpressure();
        test_clip();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
